// File: rtl/ser_2_par_shift_reg_rx.sv
// -----------------------------------------------------------------------------
// ser_2_par_shift_reg_rx
//
// Serial-to-parallel receiver. Single serial bits are collected LSB first into
// DATA_WIDTH-bit words. Each finished word is presented on a valid/ready output
// port that has one word of buffering. The serial side is stalled (din_ready
// low) only when a finished word is waiting in the assembly register while the
// output register is still occupied.
//
// Optional feature macro: PARITY_CHECK_EN
//   Defined   : one even-parity bit follows every DATA_WIDTH data bits; the
//               word completes on the parity bit and dout_perr reports the
//               XOR of data and parity bits, registered alongside dout.
//   Undefined : no parity bit is expected and dout_perr is tied to 0.
//
// Parameters:
//   DATA_WIDTH  word width in bits (>= 1)
//
// Ports:
//   clk         in   clock, rising edge active
//   resetn      in   asynchronous active-low reset
//   din         in   serial data bit
//   din_en      in   din carries a valid bit this cycle
//   din_start   in   with din_en: this bit is bit 0 of a new word
//   din_ready   out  a bit presented with din_en is accepted this cycle
//   dout        out  assembled word
//   dout_valid  out  dout holds an unconsumed word
//   dout_ready  in   downstream accepts dout this cycle
//   frame_err   out  one-cycle pulse: a partial word was aborted by din_start
//   dout_perr   out  parity error flag for the word on dout
// -----------------------------------------------------------------------------
module ser_2_par_shift_reg_rx #(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  din,
   input  logic                  din_en,
   input  logic                  din_start,
   output logic                  din_ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  frame_err,
   output logic                  dout_perr
);

   // Counter must be able to hold DATA_WIDTH itself (assembly register full).
   localparam int CNT_W = (DATA_WIDTH < 1) ? 1 : $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_FULL    = 2'd1,
      ST_PARITY  = 2'd2
   } state_t;

`ifdef PARITY_CHECK_EN
   // Even-parity check: 1 when data and parity bit together have odd weight.
   function automatic logic parity_err(input logic [DATA_WIDTH-1:0] data,
                                       input logic par_bit);
      parity_err = (^data) ^ par_bit;
   endfunction
`endif

   // Registers
   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_asm;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_dout_valid;
   logic                  r_frame_err;
   logic                  r_din_ready;
`ifdef PARITY_CHECK_EN
   logic                  r_dout_perr;
   logic                  r_perr_hold;
`endif

   // Combinational signals
   state_t                w_state_nxt;
   logic                  w_accept;
   logic                  w_out_free;
   logic                  w_ins_en;
   logic                  w_fill_done;
   logic                  w_complete;
   logic [DATA_WIDTH-1:0] w_asm_ins;
   logic [CNT_W-1:0]      w_cnt_ins;
   logic [DATA_WIDTH-1:0] w_word;
   logic [DATA_WIDTH-1:0] w_asm_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [DATA_WIDTH-1:0] w_dout_nxt;
   logic                  w_valid_nxt;
   logic                  w_ferr_nxt;
   logic                  w_ready_nxt;
`ifdef PARITY_CHECK_EN
   logic                  w_word_perr;
   logic                  w_perr_nxt;
   logic                  w_hold_nxt;
`endif

   assign w_accept   = din_en & r_din_ready;
   // Output register can take a word on this edge if empty or being drained.
   assign w_out_free = ~r_dout_valid | dout_ready;

   // Assembly register and count as they would look after inserting the
   // accepted bit; din_start restarts the word at position 0 and clears the
   // remaining positions so unwritten bits read 0.
   always_comb begin
      w_asm_ins = r_asm;
      w_cnt_ins = r_cnt + CNT_ONE;
      if (din_start) begin
         w_asm_ins    = WORD_ZERO;
         w_asm_ins[0] = din;
         w_cnt_ins    = CNT_ONE;
      end else begin
         for (int i = 0; i < DATA_WIDTH; i++) begin
            if (r_cnt == CNT_W'(i)) begin
               w_asm_ins[i] = din;
            end else begin
               w_asm_ins[i] = r_asm[i];
            end
         end
      end
   end

`ifdef PARITY_CHECK_EN
   // In PARITY only a din_start bit goes into the assembly register; a normal
   // bit there is the parity bit and completes the word already held.
   assign w_ins_en    = w_accept & ((r_state == ST_COLLECT) |
                                    ((r_state == ST_PARITY) & din_start));
   assign w_fill_done = w_ins_en & (w_cnt_ins == CNT_FULL);
   assign w_complete  = w_accept & (r_state == ST_PARITY) & ~din_start;
   assign w_word      = r_asm;
   assign w_word_perr = parity_err(r_asm, din);
`else
   assign w_ins_en    = w_accept & (r_state == ST_COLLECT);
   assign w_fill_done = w_ins_en & (w_cnt_ins == CNT_FULL);
   assign w_complete  = w_fill_done;
   assign w_word      = w_asm_ins;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_COLLECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_COLLECT: begin
`ifdef PARITY_CHECK_EN
            if (w_fill_done) begin
               w_state_nxt = ST_PARITY;
            end else begin
               w_state_nxt = ST_COLLECT;
            end
`else
            if (w_complete && !w_out_free) begin
               w_state_nxt = ST_FULL;
            end else begin
               w_state_nxt = ST_COLLECT;
            end
`endif
         end
`ifdef PARITY_CHECK_EN
         ST_PARITY: begin
            if (w_complete) begin
               w_state_nxt = w_out_free ? ST_COLLECT : ST_FULL;
            end else if (w_ins_en) begin
               // Aborted by din_start; with DATA_WIDTH=1 that bit alone
               // already fills the data part of the new word.
               w_state_nxt = w_fill_done ? ST_PARITY : ST_COLLECT;
            end else begin
               w_state_nxt = ST_PARITY;
            end
         end
`endif
         ST_FULL: begin
            if (dout_ready) begin
               w_state_nxt = ST_COLLECT;
            end else begin
               w_state_nxt = ST_FULL;
            end
         end
         default: begin
            w_state_nxt = ST_COLLECT;
         end
      endcase
   end

   // FSM output / datapath next values (all outputs are registered below)
   always_comb begin
      w_asm_nxt   = r_asm;
      w_cnt_nxt   = r_cnt;
      w_dout_nxt  = r_dout;
      w_valid_nxt = r_dout_valid & ~dout_ready;
      w_ferr_nxt  = 1'b0;
`ifdef PARITY_CHECK_EN
      w_perr_nxt  = r_dout_perr;
      w_hold_nxt  = r_perr_hold;
`endif
      if (w_ins_en) begin
         w_asm_nxt  = w_asm_ins;
         w_cnt_nxt  = w_cnt_ins;
         // Restarting over a non-empty word aborts it.
         w_ferr_nxt = din_start & (r_cnt != CNT_ZERO);
      end else begin
         w_ferr_nxt = 1'b0;
      end

      if (w_complete) begin
         if (w_out_free) begin
            w_dout_nxt  = w_word;
            w_valid_nxt = 1'b1;
            w_asm_nxt   = WORD_ZERO;
            w_cnt_nxt   = CNT_ZERO;
`ifdef PARITY_CHECK_EN
            w_perr_nxt  = w_word_perr;
`endif
         end else begin
            // Park the finished word; the FSM moves to FULL and stalls input.
            w_asm_nxt   = w_word;
            w_cnt_nxt   = CNT_FULL;
`ifdef PARITY_CHECK_EN
            w_hold_nxt  = w_word_perr;
`endif
         end
      end else if ((r_state == ST_FULL) && dout_ready) begin
         // Output drained: parked word moves up, dout_valid stays high.
         w_dout_nxt  = r_asm;
         w_valid_nxt = 1'b1;
         w_asm_nxt   = WORD_ZERO;
         w_cnt_nxt   = CNT_ZERO;
`ifdef PARITY_CHECK_EN
         w_perr_nxt  = r_perr_hold;
`endif
      end else begin
         w_dout_nxt  = r_dout;
      end

      w_ready_nxt = (w_state_nxt != ST_FULL);
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_asm        <= WORD_ZERO;
         r_cnt        <= CNT_ZERO;
         r_dout       <= WORD_ZERO;
         r_dout_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_din_ready  <= 1'b0;
`ifdef PARITY_CHECK_EN
         r_dout_perr  <= 1'b0;
         r_perr_hold  <= 1'b0;
`endif
      end else begin
         r_asm        <= w_asm_nxt;
         r_cnt        <= w_cnt_nxt;
         r_dout       <= w_dout_nxt;
         r_dout_valid <= w_valid_nxt;
         r_frame_err  <= w_ferr_nxt;
         r_din_ready  <= w_ready_nxt;
`ifdef PARITY_CHECK_EN
         r_dout_perr  <= w_perr_nxt;
         r_perr_hold  <= w_hold_nxt;
`endif
      end
   end

   assign din_ready  = r_din_ready;
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign frame_err  = r_frame_err;
`ifdef PARITY_CHECK_EN
   assign dout_perr  = r_dout_perr;
`else
   assign dout_perr  = 1'b0;
`endif

endmodule

// File: doc/ser_2_par_shift_reg_rx.md
Name: ser_2_par_shift_reg_rx

Overview:
Serial-to-parallel receiver, the receive-side counterpart of the team's parallel-to-serial shifter. Collects single-bit serial data, LSB first, into DATA_WIDTH-bit words. Presents each completed word on a valid/ready output port with one word of buffering. Applies backpressure to the serial side only when both the assembly register and the output register are occupied.

Parameters:
DATA_WIDTH, 4, word width in bits, >= 1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
resetn  input  1  asynchronous active-low reset.
din  input  1  serial data bit.
din_en  input  1  din holds a valid bit this cycle.
din_start  input  1  qualified by din_en: this bit is bit 0 of a new word.
din_ready  output  1  a bit with din_en high is accepted this cycle.
dout  output  DATA_WIDTH  assembled word.
dout_valid  output  1  dout holds an unconsumed word.
dout_ready  input  1  downstream accepts dout this cycle.
frame_err  output  1  one-cycle pulse: a partial word was aborted by din_start.
dout_perr  output  1  parity error flag for the word on dout (see Optional Feature).

Behaviour:
- Reset (resetn low, asynchronous):
  - dout=0, dout_valid=0, frame_err=0, dout_perr=0, din_ready=0.
  - Bit count and assembly register are cleared; any partial word is discarded silently, with no frame_err.
  - din_ready is 1 from the first edge after release.
- Bit acceptance: accept when din_en && din_ready.
  - The accepted bit is written to assembly position cnt, and cnt increments.
  - Unwritten positions read 0.
- din_start && din_en && din_ready:
  - The bit goes to position 0 and cnt becomes 1.
  - If the previous cnt was not 0, frame_err pulses high in the next cycle.
  - din_start without din_en is ignored.
- States: COLLECT, FULL (plus PARITY under the macro).
- COLLECT:
  - din_ready=1.
  - When the bit accepted makes cnt reach DATA_WIDTH, the word is complete.
  - If the output register is free, the word loads into dout and cnt returns to 0. "Free" means dout_valid=0, or dout_valid && dout_ready in the same cycle.
  - Otherwise the word stays in the assembly register and the state goes to FULL.
- Latency: dout_valid rises on the cycle after the last bit is accepted.
- FULL:
  - din_ready=0.
  - When dout_valid && dout_ready, the held word loads into dout, dout_valid stays 1, cnt=0, and the state returns to COLLECT.
  - din_ready is 1 on the next cycle.
- Output port:
  - dout and dout_perr hold stable while dout_valid && !dout_ready.
  - dout_valid falls after a handshake unless a new word loads on the same edge.
- DATA_WIDTH=1: every accepted bit completes a word; din_start has no abort effect.
- Back-to-back words at one bit per cycle are sustained with no bubble while dout_ready stays high.

Optional Feature:
Macro: PARITY_CHECK_EN.
- Defined:
  - After DATA_WIDTH data bits, the block enters state PARITY and expects one more accepted bit, the even-parity bit.
  - The word completes on that bit, following the same COLLECT/FULL rules.
  - dout_perr = XOR of the data bits XOR the parity bit, registered alongside dout.
  - din_start during PARITY aborts the word and raises frame_err.
  - Latency is measured from the parity bit.
- Not defined: no parity bit is expected, and dout_perr is tied to 0.

Test Plan (DATA_WIDTH=4):
1. Release reset, dout_ready=1, send bits 1,0,1,1 on consecutive cycles -> dout=0xD and dout_valid high for exactly one cycle, on the cycle after the 4th bit; frame_err stays 0.
2. dout_ready=0, send 0xD then 0x6 (bits 0,1,1,0):
   - After the 8th bit, din_ready=0 and dout stays 0xD.
   - Pulse dout_ready for one cycle -> next cycle dout=0x6, dout_valid=1, din_ready=1.
3. Send bits 1,1, then bit 0 with din_start, then 0,1,0 -> frame_err pulses once, and dout=0x4.
4. Send 2 bits, then drop resetn between edges -> dout_valid=0 and din_ready=0 immediately. Release, then send 0,0,0,1 -> dout=0x8, frame_err=0.
5. Send 1,0,0,1 with idle cycles (din_en=0) between bits, plus din_start pulsed while din_en=0 -> dout=0x9, frame_err=0.
6. With PARITY_CHECK_EN defined:
   - Send 1,1,0,0 then parity 0 -> dout=0x3, dout_perr=0.
   - Repeat with parity 1 -> dout_perr=1.
